// File: rtl/ex_pkg.sv
// Shared EX-stage definitions: operand-bus defaults and the skid-buffer state encoding.
package ex_pkg;

  localparam int unsigned EX_OPND_W    = 32;
  localparam int unsigned EX_MUX_N     = 10;
  localparam int unsigned EX_MUX_SEL_W = 4;
  localparam int unsigned EX_ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 select with range check; result is {err, data}, data forced to zero on error.
module mux_n_comb #(
  parameter int unsigned N     = 10,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEL_W = 4
) (
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH:0]     res_o
);

  always_comb begin
    res_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) begin
        res_o[WIDTH-1:0] = in_data_i[k*WIDTH +: WIDTH];
      end
    end
    // Codes at or above N carry no input; they only raise the error bit.
    if (32'(sel_i) >= N) begin
      res_o[WIDTH] = 1'b1;
    end
  end

endmodule

// File: rtl/ex_mux_pipe.sv
// EX-stage operand selector: registered output behind a 2-entry skid buffer with a
// registered in_ready, plus a saturating count of out-of-range beats.
module ex_mux_pipe
  import ex_pkg::*;
#(
  parameter int unsigned N     = EX_MUX_N,
  parameter int unsigned WIDTH = EX_OPND_W,
  parameter int unsigned SEL_W = EX_MUX_SEL_W,
  parameter int unsigned CNT_W = EX_ERR_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   err_cnt,
  input  logic               err_clr
);

  logic [WIDTH:0]   res;
  logic [WIDTH:0]   main_q, main_d;
  logic [WIDTH:0]   skid_q, skid_d;
  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  mux_n_comb #(
    .N     (N),
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_mux (
    .in_data_i (in_data),
    .sel_i     (in_sel),
    .res_o     (res)
  );

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = res;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && out_ready) begin
          main_d = res;
        end else if (accept) begin
          skid_d  = res;
          state_d = BUF_FULL;
        end else if (out_ready) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_ready) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase

    // Ready is taken from the next state so it is a flop output, decoupled from out_ready.
    in_ready_d = (state_d != BUF_FULL);

    cnt_d = cnt_q;
    if (err_clr) begin
      cnt_d = '0;
    end else if (accept && res[WIDTH] && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUF_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = main_q[WIDTH-1:0];
  assign out_err   = main_q[WIDTH];
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_mux_pipe.sv
// Scoreboard bench for ex_mux_pipe: driver queues expected beats, negedge monitor pops and compares.
module tb_ex_mux_pipe;

  localparam int unsigned N  = 10;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 4;

  localparam logic [W-1:0] TBL [N] = '{
    32'h0A0A_0000, 32'h1B1B_0001, 32'h2C2C_0002, 32'hDEAD_BEEF, 32'h4E4E_0004,
    32'h5F5F_0005, 32'h6060_0006, 32'h7171_0007, 32'h8282_0008, 32'h9393_0009
  };

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*W-1:0]  in_data;
  logic [SW-1:0]   in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    out_data;
  logic            out_err;
  logic            out_valid;
  logic            out_ready;
  logic [CW-1:0]   err_cnt;
  logic            err_clr;

  int checks   = 0;
  int failures = 0;
  int popped   = 0;
  logic [W:0] sb_q [$];

  ex_mux_pipe #(
    .N     (N),
    .WIDTH (W),
    .SEL_W (SW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] exp_of(input logic [SW-1:0] s);
    if (s < SW'(N)) return {1'b0, TBL[s]};
    return {1'b1, 32'h0};
  endfunction

  logic       stall_v = 1'b0;
  logic [W:0] stall_val;

  always @(negedge clk) begin
    if (out_valid) begin
      if (stall_v) chk("hold_stable", {out_err, out_data}, stall_val);
      if (out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none", {out_err, out_data});
        end else begin
          chk("beat", {out_err, out_data}, sb_q.pop_front());
        end
        popped++;
        stall_v = 1'b0;
      end else begin
        stall_v   = 1'b1;
        stall_val = {out_err, out_data};
      end
    end else begin
      stall_v = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; holds the beat until accepted or the budget runs out.
  task automatic beat(input logic [SW-1:0] sel, input logic ordy);
    bit done;
    done      = 1'b0;
    in_sel    = sel;
    in_valid  = 1'b1;
    out_ready = ordy;
    for (int n = 0; n < 50; n++) begin
      if (in_ready) begin
        sb_q.push_back(exp_of(sel));
        step(1);
        done = 1'b1;
        break;
      end
      step(1);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept sel=%0d", sel);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    in_valid  = 1'b0;
    in_sel    = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    for (int k = 0; k < N; k++) in_data[k*W +: W] = TBL[k];

    #3;
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    chk("rst_out_data", {out_err, out_data}, 33'h0);
    chk("rst_err_cnt", 33'(err_cnt), 33'd0);
    chk("rst_in_ready", 33'(in_ready), 33'd0);
    #9 rst_n = 1'b1;
    #1 chk("rel_in_ready_low", 33'(in_ready), 33'd0);
    step(1);
    chk("rel_in_ready_high", 33'(in_ready), 33'd1);

    // Single beat, one-cycle latency, then idle.
    beat(4'd3, 1'b1);
    chk("single_valid", 33'(out_valid), 33'd1);
    chk("single_data", {out_err, out_data}, 33'h0_DEAD_BEEF);
    step(1);
    chk("single_drain", 33'(out_valid), 33'd0);

    // Out-of-range and top in-range select.
    beat(4'd12, 1'b1);
    chk("oor_data", {out_err, out_data}, 33'h1_0000_0000);
    chk("oor_cnt", 33'(err_cnt), 33'd1);
    beat(4'd9, 1'b1);
    chk("sel9_data", {out_err, out_data}, 33'h0_9393_0009);
    chk("sel9_cnt", 33'(err_cnt), 33'd1);
    step(1);

    // Backpressure: fill both entries, stall, then drain in order.
    p0 = popped;
    beat(4'd0, 1'b0);
    beat(4'd1, 1'b0);
    chk("bp_in_ready", 33'(in_ready), 33'd0);
    chk("bp_head", {out_err, out_data}, 33'h0_0A0A_0000);
    step(3);
    chk("bp_still_full", 33'(in_ready), 33'd0);
    beat(4'd2, 1'b1);
    step(2);
    chk("bp_count", 33'(popped), 33'(p0 + 3));

    // Full throughput.
    p0        = popped;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_sel = SW'(i % 10);
      chk("tput_in_ready", 33'(in_ready), 33'd1);
      sb_q.push_back(exp_of(in_sel));
      step(1);
      chk("tput_valid", 33'(out_valid), 33'd1);
    end
    in_valid = 1'b0;
    step(1);
    chk("tput_count", 33'(popped), 33'(p0 + 20));

    // Counter clear, saturation, and clear winning over a same-cycle increment.
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    chk("clr_cnt", 33'(err_cnt), 33'd0);
    for (int i = 0; i < 17; i++) begin
      beat(SW'(10 + i % 6), 1'b1);
      if (i == 13) chk("cnt_14", 33'(err_cnt), 33'd14);
    end
    chk("cnt_sat", 33'(err_cnt), 33'd15);
    err_clr = 1'b1;
    beat(4'd11, 1'b1);
    err_clr = 1'b0;
    chk("clr_priority", 33'(err_cnt), 33'd0);
    beat(4'd15, 1'b1);
    chk("cnt_after_clr", 33'(err_cnt), 33'd1);
    step(1);

    // Asynchronous reset while FULL.
    beat(4'd4, 1'b0);
    beat(4'd5, 1'b0);
    chk("pre_rst_full", 33'(in_ready), 33'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 33'(out_valid), 33'd0);
    chk("arst_in_ready", 33'(in_ready), 33'd0);
    chk("arst_cnt", 33'(err_cnt), 33'd0);
    sb_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("post_rst_idle", 33'(out_valid), 33'd0);
    end
    p0 = popped;
    beat(4'd7, 1'b1);
    chk("post_rst_data", {out_err, out_data}, 33'h0_7171_0007);
    step(2);
    chk("post_rst_count", 33'(popped), 33'(p0 + 1));
    chk("sb_empty", 33'(sb_q.size()), 33'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
